// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand path: widths and streamer states.
// Imported by the streamer top and its operand RAM.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP,
    DONE
  } state_e;

  localparam int DEF_INT   = 6;
  localparam int DEF_FRAC  = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int op_w(input int i, input int f);
    return i + f;
  endfunction

  // Full-precision product width as seen by the MAC
  function automatic int prod_w(input int wa, input int wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/mac_operand_ram.sv
// Operand pair storage: one synchronous write port and one
// combinational read port; contents are intentionally not reset.
module mac_operand_ram
  import mac_pkg::*;
#(
  parameter int WA    = op_w(DEF_INT, DEF_FRAC),
  parameter int WB    = op_w(DEF_INT, DEF_FRAC),
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WA-1:0] wa,
  input  logic [WB-1:0] wb,
  input  logic [AW-1:0] raddr,
  output logic [WA-1:0] ra,
  output logic [WB-1:0] rb
);

  logic [WA+WB-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= {wa, wb};
    end
  end

  assign {ra, rb} = mem_q[raddr];

endmodule

// File: rtl/mac_operand_streamer.sv
// Streams len buffered (a, b) operand pairs to the MAC with valid/ready.
// Define MAC_STREAMER_GAP_EN to insert a one-cycle valid bubble per beat.
module mac_operand_streamer
  import mac_pkg::*;
#(
  parameter int INT_A  = DEF_INT,
  parameter int FRAC_A = DEF_FRAC,
  parameter int INT_B  = DEF_INT,
  parameter int FRAC_B = DEF_FRAC,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int WA    = op_w(INT_A, FRAC_A),
  localparam int WB    = op_w(INT_B, FRAC_B)
) (
  input  logic          clock,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WA-1:0] wr_a,
  input  logic [WB-1:0] wr_b,
  input  logic [LW-1:0] len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [WA-1:0] a_o,
  output logic [WB-1:0] b_o,
  output logic          valid_o,
  output logic          last_o,
  input  logic          ready_i
);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [WA-1:0] a_q, a_d;
  logic [WB-1:0] b_q, b_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  logic [AW-1:0] rd_addr;
  logic [WA-1:0] ra;
  logic [WB-1:0] rb;
  logic          ram_we;
  logic [LW-1:0] len_clamp;
  logic [LW-1:0] idx_p2;

  // Buffer is only writable while idle so a frame never sees torn data
  assign ram_we = wr_en && (state_q == IDLE);

  assign len_clamp = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
  assign idx_p2    = LW'(idx_q) + LW'(2);

  mac_operand_ram #(
    .WA    (WA),
    .WB    (WB),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_addr),
    .wa    (wr_a),
    .wb    (wr_b),
    .raddr (rd_addr),
    .ra    (ra),
    .rb    (rb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    last_d  = last_q;
    rd_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else begin
            len_d   = len_clamp;
            idx_d   = '0;
            a_d     = ra;
            b_d     = rb;
            valid_d = 1'b1;
            last_d  = (len_clamp == LW'(1));
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        rd_addr = idx_q + AW'(1);
        if (valid_q && ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d  = rd_addr;
            a_d    = ra;
            b_d    = rb;
            // next beat is last when idx+1 == len-1
            last_d = (idx_p2 == len_q);
`ifdef MAC_STREAMER_GAP_EN
            valid_d = 1'b0;
            state_d = GAP;
`endif
          end
        end
      end
`ifdef MAC_STREAMER_GAP_EN
      GAP: begin
        valid_d = 1'b1;
        state_d = STREAM;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Scoreboard bench for mac_operand_streamer: a buffer model predicts
// each frame's beats; a negedge monitor checks them as they transfer.
module tb_mac_operand_streamer;
  import mac_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;
  localparam int WA    = 14;
  localparam int WB    = 14;

  logic          clock   = 1'b0;
  logic          rstn    = 1'b1;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WA-1:0] wr_a    = '0;
  logic [WB-1:0] wr_b    = '0;
  logic [LW-1:0] len     = '0;
  logic          start   = 1'b0;
  logic          ready_i = 1'b0;
  logic          busy;
  logic          done;
  logic [WA-1:0] a_o;
  logic [WB-1:0] b_o;
  logic          valid_o;
  logic          last_o;

  mac_operand_streamer #(
    .INT_A  (6),
    .FRAC_A (8),
    .INT_B  (6),
    .FRAC_B (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clock   (clock),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .len     (len),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_o     (a_o),
    .b_o     (b_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          last;
  } beat_t;

  beat_t         sb_q[$];
  bit            dq[$];
  logic [WA-1:0] m_a[DEPTH];
  logic [WB-1:0] m_b[DEPTH];
  int            checks = 0;
  int            passed = 0;
  int            frames_started = 0;
  int            frames_done = 0;
  bit            ready_rand = 1'b0;
  bit            ready_force = 1'b1;

  task automatic check(input bit ok, input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clock) begin
    #2;
    ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor
  beat_t         bt;
  bit            ab;
  logic [WA-1:0] pa;
  logic [WB-1:0] pb;
  bit            pl, stall_p, xnl_p, lx_p, st_p, done_p;
`ifdef MAC_STREAMER_GAP_EN
  bit            gap_p;
`endif

  always @(negedge clock) begin
    if (!rstn) begin
      stall_p = 0; xnl_p = 0; lx_p = 0; st_p = 0; done_p = 0;
`ifdef MAC_STREAMER_GAP_EN
      gap_p = 0;
`endif
    end else begin
      if (stall_p) begin
        check(valid_o === 1'b1, "stall_valid", 32'(valid_o), 1);
        check({a_o, b_o, last_o} === {pa, pb, pl}, "stall_hold",
              32'({a_o, b_o}), 32'({pa, pb}));
      end
`ifdef MAC_STREAMER_GAP_EN
      if (xnl_p) check(valid_o === 1'b0, "gap_bubble", 32'(valid_o), 0);
      if (gap_p) check(valid_o === 1'b1, "gap_resume", 32'(valid_o), 1);
`else
      if (xnl_p) check(valid_o === 1'b1, "back_to_back", 32'(valid_o), 1);
`endif
      if (done_p) check(busy === 1'b0, "busy_after_done", 32'(busy), 0);
      if (valid_o === 1'b1 && ready_i) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "extra_beat", 32'(a_o), 0);
        end else begin
          bt = sb_q.pop_front();
          check(a_o === bt.a, "beat_a", 32'(a_o), 32'(bt.a));
          check(b_o === bt.b, "beat_b", 32'(b_o), 32'(bt.b));
          check(last_o === bt.last, "beat_last", 32'(last_o), 32'(bt.last));
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) begin
          check(1'b0, "unexpected_done", 1, 0);
        end else begin
          ab = dq.pop_front();
          if (ab) check(lx_p, "done_after_last", 32'(lx_p), 1);
          else check(st_p, "done_len0", 32'(st_p), 1);
          frames_done++;
        end
      end
`ifdef MAC_STREAMER_GAP_EN
      gap_p = xnl_p;
`endif
      stall_p = (valid_o === 1'b1) && !ready_i;
      pa = a_o; pb = b_o; pl = last_o;
      xnl_p = (valid_o === 1'b1) && ready_i && !last_o;
      lx_p  = (valid_o === 1'b1) && ready_i && last_o;
      st_p  = start;
      done_p = (done === 1'b1);
    end
  end

  // Reference: a frame reads entries 0..min(len,DEPTH)-1 of the buffer
  task automatic expect_frame(input int l);
    int    n;
    beat_t e;
    n = (l > DEPTH) ? DEPTH : l;
    for (int i = 0; i < n; i++) begin
      e.a = m_a[i];
      e.b = m_b[i];
      e.last = (i == n - 1);
      sb_q.push_back(e);
    end
    dq.push_back(n != 0);
    frames_started++;
  endtask

  task automatic wr(input int ad, input logic [WA-1:0] a,
                    input logic [WB-1:0] b);
    wr_en = 1'b1; wr_addr = AW'(ad); wr_a = a; wr_b = b;
    @(posedge clock); #1;
    wr_en = 1'b0;
    m_a[ad] = a; m_b[ad] = b;
  endtask

  task automatic do_start(input int l, input bit junk, input bit wr0);
    expect_frame(l);
    len = LW'(l);
    start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = '0;
      wr_a = WA'($urandom); wr_b = WB'($urandom);
    end
    @(posedge clock); #1;
    if (wr0) begin
      m_a[0] = wr_a; m_b[0] = wr_b;
    end
    start = 1'b0; wr_en = 1'b0;
    if (junk) begin
      wr_en = 1'b1; wr_addr = AW'($urandom);
      wr_a = WA'($urandom); wr_b = WB'($urandom);
      start = 1'b1; len = LW'($urandom);
      @(posedge clock); #1;
      wr_en = 1'b0; start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 300;
    while (frames_done != frames_started && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    if (budget == 0) check(1'b0, "timeout", frames_done, frames_started);
    @(posedge clock); #1;
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1;
    check(valid_o === 1'b0, "rst_valid", 32'(valid_o), 0);
    check(last_o === 1'b0, "rst_last", 32'(last_o), 0);
    check(busy === 1'b0, "rst_busy", 32'(busy), 0);
    check(done === 1'b0, "rst_done", 32'(done), 0);
    check(a_o === '0 && b_o === '0, "rst_data", 32'({a_o, b_o}), 0);
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;

    for (int i = 0; i < DEPTH; i++) wr(i, WA'($urandom), WB'($urandom));
    wr(0, 14'h0100, 14'h0100);
    wr(1, 14'h0200, 14'h0080);
    wr(2, 14'h0300, 14'h3F00);

    do_start(3, 0, 0);
    wait_idle();

    // Stall beat 2 for four cycles
    do_start(3, 0, 0);
    @(posedge clock); #1 ready_force = 1'b0;
    repeat (4) @(posedge clock);
    #1 ready_force = 1'b1;
    wait_idle();

    do_start(0, 0, 0);
    wait_idle();
    do_start(20, 1, 0);
    wait_idle();
    do_start(16, 0, 0);
    wait_idle();
    do_start(4, 0, 1);
    wait_idle();
    do_start(2, 0, 0);
    wait_idle();

    // Reset while beat 2 is stalled
    do_start(3, 0, 0);
    @(posedge clock); #1 ready_force = 1'b0;
    repeat (2) @(posedge clock);
    #3 rstn = 1'b0;
    #1;
    check(valid_o === 1'b0, "abort_valid", 32'(valid_o), 0);
    check(last_o === 1'b0, "abort_last", 32'(last_o), 0);
    check(busy === 1'b0, "abort_busy", 32'(busy), 0);
    check(done === 1'b0, "abort_done", 32'(done), 0);
    check(a_o === '0 && b_o === '0, "abort_data", 32'({a_o, b_o}), 0);
    sb_q.delete();
    dq.delete();
    frames_started = frames_done;
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;
    ready_force = 1'b1;
    do_start(2, 0, 0);
    wait_idle();

    ready_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        wr(int'($urandom_range(0, DEPTH - 1)),
           WA'($urandom), WB'($urandom));
      end
      do_start(int'($urandom_range(0, 20)),
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0);
      wait_idle();
    end
    ready_rand = 1'b0;

    check(sb_q.size() == 0, "beats_left", sb_q.size(), 0);
    check(dq.size() == 0, "dones_left", dq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mac_operand_streamer.md
Name: mac_operand_streamer

Overview:
AXI-stream-style source that drives fixed-point operand pairs (a, b) into the MAC consumer. Software/testbench preloads two operand vectors into an internal buffer and pulses start. The block then streams len beats with valid/last, honouring ready backpressure. It is the transmit end of the MAC operand interface; its a_o/b_o/valid_o/last_o connect directly to the MAC's a/b/valid_i/last_i, and ready_i comes from the MAC's ready_i source.

Parameters:
INT_A, 6, integer bits of operand a
FRAC_A, 8, fraction bits of operand a
INT_B, 6, integer bits of operand b
FRAC_B, 8, fraction bits of operand b
DEPTH, 16, buffer entries (power of 2, >=2)
AW, $clog2(DEPTH), address width (derived, not overridden)
LW, $clog2(DEPTH)+1, length width (derived)

Ports:
clock  in  1  clock, rising edge
rstn  in  1  reset; asynchronous, active-low
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_a  in  INT_A+FRAC_A  signed operand a write data
wr_b  in  INT_B+FRAC_B  signed operand b write data
len  in  LW  beats per frame, sampled on start
start  in  1  begin frame (one-cycle pulse)
busy  out  1  frame in progress
done  out  1  one-cycle pulse after last beat accepted
a_o  out  INT_A+FRAC_A  signed operand a to MAC
b_o  out  INT_B+FRAC_B  signed operand b to MAC
valid_o  out  1  beat valid
last_o  out  1  final beat of frame
ready_i  in  1  sink ready

Behaviour:
- Reset (async, rstn=0): state IDLE; idx=0; a_o=0, b_o=0, valid_o=0, last_o=0, busy=0, done=0. Buffer contents not reset (undefined until written). Reset mid-frame aborts immediately; no done pulse.
- FSM: IDLE, STREAM, DONE.
- IDLE: wr_en=1 writes mem_a[wr_addr]=wr_a, mem_b[wr_addr]=wr_b at the clock edge. start=1 samples len:
  - len=0 -> DONE directly, no beats.
  - len>DEPTH -> clamped to DEPTH.
  - otherwise latch len, idx=0, go STREAM.
- Timing: start at edge k -> at edge k the outputs are registered to a_o=mem_a[0], b_o=mem_b[0], valid_o=1, last_o=(len==1), busy=1. Write-then-start same cycle: write wins ordering; a start coincident with a write to addr 0 sends the old entry-0 data.
- STREAM: a transfer occurs on an edge where valid_o && ready_i.
  - On a transfer with !last_o: idx++, a_o/b_o load entry idx+1, last_o=(idx+1==len-1), valid_o stays 1.
  - On a transfer with last_o: valid_o=0, last_o=0, go DONE.
  - While valid_o && !ready_i: a_o, b_o, last_o held stable; valid_o never deasserts before transfer.
- DONE: done=1 for exactly one cycle, busy=0 on exit, return to IDLE. a_o/b_o retain their last values.
- busy=1 in STREAM and DONE.
- While busy, wr_en and start are ignored (no buffer corruption, no restart).
- Throughput: one beat per cycle when ready_i is held high. A len-N frame occupies N cycles of valid_o, then 1 cycle of DONE.
- Widths: data passes through bit-exact, no arithmetic; sign preserved.

Optional Feature:
MAC_STREAMER_GAP_EN:
- Defined: after every accepted non-last beat, valid_o drops for exactly one cycle (GAP sub-state) before the next beat is presented. A len-N frame with ready_i=1 takes 2N-1 valid/gap cycles. last_o and data rules are otherwise unchanged. Used to exercise sink handling of valid bubbles.
- Undefined: back-to-back beats as specified above; no GAP state is synthesised.

Decomposition:
- Shared package mac_pkg:
  - width localparams/functions (operand width = INT+FRAC, product width rules shared with the MAC);
  - state typedef enum {IDLE, STREAM, GAP, DONE}.
- One sub-module, mac_operand_ram:
  - DEPTH x (wa+wb) storage;
  - single write port, one combinational read port addressed by the FSM's next-index;
  - the streamer registers its outputs.

Test Plan:
- Write a=[0x0100,0x0200,0x0300], b=[0x0100,0x0080,0xFF00], len=3, start, ready_i=1 -> 3 consecutive beats with those pairs, last_o only on beat 3, done pulses 1 cycle after beat 3, busy low after.
- Same frame, ready_i low for 4 cycles during beat 2 -> a_o=0x0200/b_o=0x0080, valid_o=1, last_o=0 held stable for all stall cycles; beat 3 follows the first ready cycle.
- len=0 start -> no valid_o, done pulses next cycle. len=20 (DEPTH=16) -> exactly 16 beats, last_o on entry 15.
- Start and wr_en pulsed while busy -> ignored: frame completes unchanged, buffer entry unchanged on a later readback frame.
- rstn asserted while beat 2 stalled -> outputs zero asynchronously, no done; a new start after release streams from entry 0.
- With MAC_STREAMER_GAP_EN, len=3, ready_i=1 -> valid_o pattern 1,0,1,0,1, then done.
